// File: rtl/latency_pkg.sv
// latency_pkg
//   Shared definitions for the latency tracker slice: default widths,
//   statistic reset constants, the completion classification enum and a
//   saturating adder shared by the sum, count and histogram registers.
//   Optional histogram feature macro: LATENCY_TRACKER_HIST_EN.
package latency_pkg;

  localparam int DEF_CNT_W      = 40;
  localparam int DEF_TAG_W      = 8;
  localparam int DEF_SUM_W      = 64;
  localparam int DEF_NUM_W      = 32;
  localparam int DEF_HIST_SHIFT = 4;
  localparam int HIST_BINS      = 16;

  // Widest accumulator the saturating adder handles.
  localparam int SAT_W = 64;

  // stat_min starts at all ones so the first real latency always wins.
  localparam logic [SAT_W-1:0] MIN_INIT = '1;

  // What stage 0 captured from the completion side in a given cycle.
  typedef enum logic [1:0] {
    RX_NONE   = 2'd0,
    RX_HIT    = 2'd1,
    RX_ORPHAN = 2'd2
  } rx_kind_e;

  // Adds inc to acc and clamps at the all-ones value of a width-bit field.
  // Operands are zero-extended to SAT_W by the caller; width <= SAT_W.
  function automatic logic [SAT_W-1:0] sat_add(input logic [SAT_W-1:0] acc,
                                               input logic [SAT_W-1:0] inc,
                                               input int               width);
    logic [SAT_W-1:0] top;
    if (width >= SAT_W) top = '1;
    else                top = (SAT_W'(1) << width) - SAT_W'(1);
    if (inc > top || acc > top - inc) sat_add = top;
    else                              sat_add = acc + inc;
  endfunction

endpackage

// File: rtl/latency_tracker_if.sv
// latency_tracker_if
//   Request/completion bundle between the TX/RX engines and the tracker.
//   master : engine side, drives issues and completions, sees results
//   slave  : tracker side
//   Signals: tx_valid/tx_tag (issue), rx_valid/rx_tag (completion),
//            lat_valid/lat_value/lat_tag (per-completion latency result).
interface latency_tracker_if
  import latency_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int TAG_W = DEF_TAG_W
);

  logic             tx_valid;
  logic [TAG_W-1:0] tx_tag;
  logic             rx_valid;
  logic [TAG_W-1:0] rx_tag;
  logic             lat_valid;
  logic [CNT_W-1:0] lat_value;
  logic [TAG_W-1:0] lat_tag;

  modport master (
    output tx_valid, tx_tag, rx_valid, rx_tag,
    input  lat_valid, lat_value, lat_tag
  );

  modport slave (
    input  tx_valid, tx_tag, rx_valid, rx_tag,
    output lat_valid, lat_value, lat_tag
  );

endinterface

// File: rtl/latency_stamp_ram.sv
// latency_stamp_ram
//   Simple dual-port timestamp store, one entry per tag.
//   Ports: clk; wr_en/wr_addr/wr_data (port A, write);
//          rd_addr/rd_data (port B, registered read, 1-cycle latency).
//   A read and write to the same address in one cycle return the old
//   contents. No reset on the array so it maps onto block RAM.
module latency_stamp_ram
  import latency_pkg::*;
#(
  parameter int AW = DEF_TAG_W,
  parameter int DW = DEF_CNT_W
)(
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [0:(2**AW)-1];

  // Both ports in one block: the non-blocking read sees the pre-write value.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/latency_tracker.sv
// latency_tracker
//   Timestamps requests by tag from a free-running counter and reports the
//   round-trip latency when the matching completion arrives, two cycles
//   after rx_valid. Keeps min/max/saturating sum/saturating count, the
//   number of tags in flight and sticky orphan/reuse error flags.
//   Ports: clk, rst_n (async, active low), clr (sync clear);
//          bus (latency_tracker_if.slave) issue/completion/result;
//          stat_min/stat_max/stat_sum/stat_num, outstanding,
//          err_orphan, err_reuse.
//   Optional macro LATENCY_TRACKER_HIST_EN adds a 16-bin latency histogram
//   with hist_sel (in) and hist_data (out, registered) ports.
module latency_tracker
  import latency_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int TAG_W = DEF_TAG_W,
  parameter int SUM_W = DEF_SUM_W,
  parameter int NUM_W = DEF_NUM_W
`ifdef LATENCY_TRACKER_HIST_EN
  ,
  parameter int HIST_SHIFT = DEF_HIST_SHIFT
`endif
)(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  latency_tracker_if.slave   bus,
  output logic [CNT_W-1:0]   stat_min,
  output logic [CNT_W-1:0]   stat_max,
  output logic [SUM_W-1:0]   stat_sum,
  output logic [NUM_W-1:0]   stat_num,
  output logic [TAG_W:0]     outstanding,
  output logic               err_orphan,
  output logic               err_reuse
`ifdef LATENCY_TRACKER_HIST_EN
  ,
  input  logic [3:0]         hist_sel,
  output logic [NUM_W-1:0]   hist_data
`endif
);

  localparam int DEPTH = 2**TAG_W;

  logic [CNT_W-1:0] now;
  logic [DEPTH-1:0] inflight;
  logic [DEPTH-1:0] inflight_next;

  logic             tx_valid;
  logic             rx_valid;
  logic [TAG_W-1:0] tx_tag;
  logic [TAG_W-1:0] rx_tag;
  logic             tx_busy;
  logic             rx_busy;
  logic             same_tag;
  logic             issue_new;
  logic             reuse;
  logic             rx_hit;
  logic             rx_orphan;

  rx_kind_e         s0_kind;
  logic [TAG_W-1:0] s0_tag;
  logic [CNT_W-1:0] s0_now;
  logic [CNT_W-1:0] stamp_q;
  logic [CNT_W-1:0] delta;

  // A clear cycle ignores the engines entirely so nothing leaks past it.
  assign tx_valid = bus.tx_valid & ~clr;
  assign rx_valid = bus.rx_valid & ~clr;
  assign tx_tag   = bus.tx_tag;
  assign rx_tag   = bus.rx_tag;

  // Classification uses the in-flight state before this cycle's updates.
  // A same-tag issue and completion retires the old request and starts a
  // new one, which is neither a reuse nor (if in flight) an orphan.
  assign tx_busy   = inflight[tx_tag];
  assign rx_busy   = inflight[rx_tag];
  assign same_tag  = tx_valid & rx_valid & (tx_tag == rx_tag);
  assign rx_hit    = rx_valid & rx_busy;
  assign rx_orphan = rx_valid & ~rx_busy;
  assign reuse     = tx_valid & tx_busy & ~same_tag;
  assign issue_new = tx_valid & (~tx_busy | same_tag);

  latency_stamp_ram #(
    .AW (TAG_W),
    .DW (CNT_W)
  ) u_stamp_ram (
    .clk     (clk),
    .wr_en   (tx_valid),
    .wr_addr (tx_tag),
    .wr_data (now),
    .rd_addr (rx_tag),
    .rd_data (stamp_q)
  );

  // Clear on completion first, then set on issue, so a same-tag pair ends
  // with the tag still in flight.
  always_comb begin
    inflight_next = inflight;
    if (rx_valid) inflight_next[rx_tag] = 1'b0;
    if (tx_valid) inflight_next[tx_tag] = 1'b1;
  end

  // Timestamp counter, in-flight bitmap, outstanding count, sticky errors.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      now         <= '0;
      inflight    <= '0;
      outstanding <= '0;
      err_orphan  <= 1'b0;
      err_reuse   <= 1'b0;
    end else if (clr) begin
      now         <= '0;
      inflight    <= '0;
      outstanding <= '0;
      err_orphan  <= 1'b0;
      err_reuse   <= 1'b0;
    end else begin
      now         <= now + CNT_W'(1);
      inflight    <= inflight_next;
      outstanding <= outstanding + (TAG_W+1)'(issue_new) - (TAG_W+1)'(rx_hit);
      if (reuse)     err_reuse  <= 1'b1;
      if (rx_orphan) err_orphan <= 1'b1;
    end
  end

  // Completion stage 0: capture tag, arrival time and hit/orphan while the
  // stamp RAM read is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_kind <= RX_NONE;
      s0_tag  <= '0;
      s0_now  <= '0;
    end else if (clr) begin
      s0_kind <= RX_NONE;
      s0_tag  <= '0;
      s0_now  <= '0;
    end else begin
      if (rx_hit)         s0_kind <= RX_HIT;
      else if (rx_orphan) s0_kind <= RX_ORPHAN;
      else                s0_kind <= RX_NONE;
      s0_tag <= rx_tag;
      s0_now <= now;
    end
  end

  // Modular subtraction keeps the result right across a counter wrap.
  assign delta = s0_now - stamp_q;

  // Result register and statistics, updated together with lat_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.lat_valid <= 1'b0;
      bus.lat_value <= '0;
      bus.lat_tag   <= '0;
      stat_min      <= CNT_W'(MIN_INIT);
      stat_max      <= '0;
      stat_sum      <= '0;
      stat_num      <= '0;
    end else if (clr) begin
      bus.lat_valid <= 1'b0;
      bus.lat_value <= '0;
      bus.lat_tag   <= '0;
      stat_min      <= CNT_W'(MIN_INIT);
      stat_max      <= '0;
      stat_sum      <= '0;
      stat_num      <= '0;
    end else begin
      bus.lat_valid <= (s0_kind == RX_HIT);
      if (s0_kind == RX_HIT) begin
        bus.lat_value <= delta;
        bus.lat_tag   <= s0_tag;
        if (delta < stat_min) stat_min <= delta;
        if (delta > stat_max) stat_max <= delta;
        stat_sum <= SUM_W'(sat_add(SAT_W'(stat_sum), SAT_W'(delta), SUM_W));
        stat_num <= NUM_W'(sat_add(SAT_W'(stat_num), SAT_W'(1), NUM_W));
      end
    end
  end

`ifdef LATENCY_TRACKER_HIST_EN
  logic [NUM_W-1:0] hist_bins [HIST_BINS];
  logic [CNT_W-1:0] hist_shifted;
  logic [3:0]       hist_idx;

  // Anything beyond the last bin's range lands in the last bin.
  assign hist_shifted = delta >> HIST_SHIFT;
  assign hist_idx     = (hist_shifted > CNT_W'(HIST_BINS-1)) ? 4'(HIST_BINS-1)
                                                             : hist_shifted[3:0];

  // Histogram bins count alongside the statistics; hist_data is a
  // registered read of the selected bin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < HIST_BINS; i++) hist_bins[i] <= '0;
      hist_data <= '0;
    end else if (clr) begin
      for (int i = 0; i < HIST_BINS; i++) hist_bins[i] <= '0;
      hist_data <= '0;
    end else begin
      if (s0_kind == RX_HIT)
        hist_bins[hist_idx] <= NUM_W'(sat_add(SAT_W'(hist_bins[hist_idx]), SAT_W'(1), NUM_W));
      hist_data <= hist_bins[hist_sel];
    end
  end
`endif

endmodule

// File: doc/latency_tracker.md
Name: latency_tracker

Overview:
- Parametrised successor of the single-BRAM echo latency store.
- Timestamps each outgoing request by tag from an internal free-running counter. On the matching completion it computes the round-trip latency.
- Keeps min/max/sum/count statistics and flags protocol errors (orphan completion, tag reuse).
- Sits between TX_ENGINE (issue side) and RX_ENGINE (completion side). Stats are read by VIO/registers.

Parameters:
- CNT_W, 40, width of timestamp counter and of latency values
- TAG_W, 8, tag width; depth = 2**TAG_W outstanding entries
- SUM_W, 64, latency accumulator width (saturating)
- NUM_W, 32, completed-transaction counter width (saturating)
- HIST_SHIFT, 4, histogram bin granularity (optional feature only)

Ports:
- clk  in  1  design clock (250 MHz)
- rst_n  in  1  asynchronous active-low reset
- clr  in  1  synchronous user clear (from RX_ENGINE/VIO)
- tx_valid  in  1  request issued this cycle
- tx_tag  in  TAG_W  tag of issued request
- rx_valid  in  1  completion received this cycle
- rx_tag  in  TAG_W  tag of completion
- lat_valid  out  1  one-cycle pulse, new latency result
- lat_value  out  CNT_W  latency of that completion, in clk cycles
- lat_tag  out  TAG_W  tag of that result
- stat_min  out  CNT_W  minimum latency seen
- stat_max  out  CNT_W  maximum latency seen
- stat_sum  out  SUM_W  saturating sum of latencies
- stat_num  out  NUM_W  saturating count of valid completions
- outstanding  out  TAG_W+1  number of tags currently in flight
- err_orphan  out  1  sticky: completion on a tag not in flight
- err_reuse  out  1  sticky: issue on a tag already in flight

Behaviour:
- Reset/clr values: timestamp counter 0, all in-flight bits 0, stat_min all ones, stat_max 0, sum/num 0, outstanding 0, err_* 0, lat_valid 0, lat_value/lat_tag 0.
- The timestamp counter increments every cycle and wraps modulo 2**CNT_W.
- Issue (tx_valid): in the same cycle, write the counter value into stamp RAM[tx_tag] and set inflight[tx_tag].
  - If the tag is already set, overwrite the stamp and set err_reuse. outstanding is not incremented.
- Completion pipeline:
  - Stage 0 (rx_valid): register rx_tag, the counter value and inflight[rx_tag]. Issue the RAM read, which is synchronous with 1-cycle latency. Clear inflight[rx_tag].
  - Stage 1: delta = now_captured - stamp, modulo 2**CNT_W, so wrap is correct for latencies < 2**CNT_W.
  - Stage 2: lat_valid pulses; stats update.
  - Total latency from rx_valid to lat_valid is 2 cycles, fully pipelined: one completion per cycle.
- Stats update: min/max compare against delta. sum += delta, saturating at all ones. num += 1, saturating.
- Orphan (inflight bit 0 at stage 0): set err_orphan, no lat_valid, no stat update.
- Same-tag tx and rx in the same cycle: the completion uses the old stamp (read-before-write). The new issue is recorded and inflight ends at 1. Neither error is raised if the tag was in flight.
- Counter for outstanding: +1 on a valid new issue, -1 on a valid completion, net 0 if both. It never exceeds 2**TAG_W.
- clr mid-operation: all in-flight pipeline stages are squashed (no lat_valid in the next 2 cycles). RAM contents are not cleared; they are masked by the inflight bits.
- Stat outputs are registered and update in the same cycle lat_valid is asserted.

Optional Feature:
- Macro LATENCY_TRACKER_HIST_EN.
- Defined: adds a 16-bin histogram. bin = min(delta >> HIST_SHIFT, 15), with each bin a NUM_W saturating counter. Adds ports hist_sel (in, 4 bits) and hist_data (out, NUM_W bits, registered, 1-cycle read). Bins are cleared by rst_n/clr.
- Undefined: no histogram logic and no hist ports.

Decomposition:
- Shared package latency_pkg: default widths, stat reset constants (MIN_INIT = all ones), and a saturating-add function.
- One sub-module, latency_stamp_ram: simple dual-port RAM, write port A, read port B, 1-cycle registered read, read-before-write on address collision. Infers BRAM.

Test Plan:
- Reset, issue tag 3 at counter 10, complete tag 3 at counter 110 -> lat_valid 2 cycles later, lat_value 100, lat_tag 3, min=max=sum=100, num=1, outstanding returns to 0.
- Counter preset near wrap (force stamp 2**40-5), complete 20 cycles later -> lat_value 20, no error.
- Completion on never-issued tag 7 -> err_orphan=1, no lat_valid, stats unchanged. Issue tag 5 twice -> err_reuse=1, outstanding=1.
- Back-to-back completions on tags 0..3 with latencies 50/30/70/40 -> four consecutive lat_valid pulses, min 30, max 70, sum 190, num 4.
- Same-cycle tx+rx on tag 9 (previous stamp 100, now 160) -> lat_value 60, inflight[9] stays 1; next rx on tag 9 measures from 160.
- clr asserted one cycle after rx_valid -> no lat_valid, all stats at init values, outstanding 0.
